serializador_tx: RTL and testbench
==================================

SERIALIZADOR_TX -- requirements
Module: serializador_tx

Interface
REQ-001 SHALL have parameter n, default 8: data word width in bits, n >= 1.
REQ-002 SHALL have parameter DIV, default 4: clock cycles per transmitted bit, DIV >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to transmit x; sampled on the rising edge of clk.
REQ-006 SHALL have port x  input  n  parallel word to transmit; sampled on the edge where start is accepted.
REQ-007 SHALL have port sdata  output  1  serial line; idle level 1.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY when enabled, per REQ-024).
REQ-011 SHALL, in IDLE, drive sdata=1 and busy=0.
REQ-012 SHALL accept start only in IDLE; on acceptance, capture x into an internal shift register and enter START on the same edge.
REQ-013 SHALL ignore start in every state other than IDLE; x changes during a frame have no effect.
REQ-014 SHALL drive sdata=0 in START, starting the cycle after acceptance (latency 1 cycle).
REQ-015 SHALL, in DATA, transmit the captured word LSB first, bit i on sdata during the (i+1)-th data bit period.
REQ-016 SHALL drive sdata=1 in STOP.
REQ-017 SHALL hold every bit (start, data, parity, stop) on sdata for exactly DIV clock cycles, timed by a cycles-per-bit counter of width max(1, clog2(DIV)) that wraps to 0 at DIV-1.
REQ-018 SHALL count data bits with a counter of width clog2(n+1); leave DATA after exactly n bits.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL return to IDLE on the edge ending the last STOP cycle and assert done=1 for exactly that first IDLE cycle; done=0 at all other times.
REQ-021 SHALL accept a start presented during the done cycle, yielding back-to-back frames with no idle gap beyond that single cycle.
REQ-022 SHALL make frame length (n+2)*DIV cycles from the first START cycle to the last STOP cycle, inclusive, without parity.

Reset
REQ-023 SHALL, while clear=0, immediately and independently of clk force state IDLE, sdata=1, busy=0, done=0, and all counters and the shift register to 0, aborting any frame in progress; the first accepted start after release begins a full new frame.

Configuration
REQ-024 SHALL, when macro SERIALIZADOR_PARITY_EN is defined, insert state PARITY between DATA and STOP, transmitting one even-parity bit (XOR of all n captured bits) for DIV cycles; frame length becomes (n+3)*DIV.
REQ-025 SHALL, without SERIALIZADOR_PARITY_EN, contain no parity state or logic; DATA proceeds directly to STOP.

Verification
REQ-026 SHALL cover: n=8, DIV=4, start with x=8'hA5 -> sdata 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high 40 cycles; done pulse on cycle 41.
REQ-027 SHALL cover: SERIALIZADOR_PARITY_EN defined, x=8'h07 -> parity bit 1 after data bits, frame 44 cycles; x=8'h03 -> parity bit 0.
REQ-028 SHALL cover: start pulsed with x=8'hFF during DATA of a frame carrying 8'h00 -> 8'h00 frame completes unchanged, no second frame.
REQ-029 SHALL cover: clear=0 mid-DATA -> sdata=1, busy=0, done=0 before next clk edge; a later start with x=8'h3C -> complete correct frame.
REQ-030 SHALL cover: start held high continuously with x=8'h55 then 8'hAA -> two frames separated by exactly one idle cycle carrying the done pulse.
REQ-031 SHALL cover: DIV=1, n=1, x=1'b1 -> sdata 0,1,1 on consecutive cycles, done on the fourth cycle.

Source files
------------

// File: rtl/serializador_tx.sv
// rtl/serializador_tx.sv - serializer: start bit, n data bits LSB first, stop bit, DIV clocks per bit
// Defining SERIALIZADOR_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module serializador_tx #(
  parameter int n   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic [n-1:0] x,
  output logic         sdata,
  output logic         busy,
  output logic         done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(n + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(n - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef SERIALIZADOR_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [n-1:0]  shift_q, shift_d;
  logic          done_q, done_d;
`ifdef SERIALIZADOR_PARITY_EN
  logic          par_q, par_d;
`endif

  // Last cycle of the current bit period.
  logic bit_tick;
  assign bit_tick = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = START;
      START: if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick && (bit_q == BIT_LAST)) begin
`ifdef SERIALIZADOR_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef SERIALIZADOR_PARITY_EN
      PARITY: if (bit_tick) state_d = STOP;
`endif
      STOP:  if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sdata = 1'b1;
    busy  = 1'b1;
    case (state_q)
      IDLE:  busy  = 1'b0;
      START: sdata = 1'b0;
      DATA:  sdata = shift_q[0];
`ifdef SERIALIZADOR_PARITY_EN
      PARITY: sdata = par_q;
`endif
      default: sdata = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // The word is captured only on acceptance, so x is don't-care for the rest of the frame.
  always_comb begin
    cnt_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q == IDLE) begin
      bit_d = '0;
      if (start) begin
        shift_d = x;
`ifdef SERIALIZADOR_PARITY_EN
        par_d   = ^x;
`endif
      end
    end else begin
      cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
      if ((state_q == DATA) && bit_tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
      end
      if ((state_q == STOP) && bit_tick) begin
        done_d = 1'b1;
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_serializador_tx.sv
// tb/tb_serializador_tx.sv - scoreboard bench: random and directed frames against a frame-level model
module tb_serializador_tx;

  localparam int N = 8;
  localparam int D = 4;
`ifdef SERIALIZADOR_PARITY_EN
  localparam int NB = N + 3;
`else
  localparam int NB = N + 2;
`endif
  localparam int FL = NB * D;

  typedef struct {
    logic [N-1:0] w;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [N-1:0] x;
  logic         sdata, busy, done;
  logic         start1;
  logic [0:0]   x1;
  logic         sdata1, busy1, done1;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   model_busy = 0;
  bit   last_acc;
  exp_t exp_q[$];
  bit   cap[$];
  bit   prev_busy = 1'b0;
  int   first_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializador_tx #(.n(N), .DIV(D)) u_dut (
    .clk(clk), .clear(clear), .start(start), .x(x),
    .sdata(sdata), .busy(busy), .done(done)
  );

  serializador_tx #(.n(1), .DIV(1)) u_dut1 (
    .clk(clk), .clear(clear), .start(start1), .x(x1),
    .sdata(sdata1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rnd();
    return N'($urandom);
  endfunction

  // Frame bit j: start, data LSB first, optional even parity, stop.
  function automatic bit exp_bit(input logic [N-1:0] w, input int j);
    if (j == 0) return 1'b0;
    if (j <= N) return w[j-1];
`ifdef SERIALIZADOR_PARITY_EN
    if (j == N + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // One cycle of stimulus; the model accepts only when no frame occupies this cycle.
  task automatic cycle(input bit st, input logic [N-1:0] xv);
    start = st;
    x     = xv;
    last_acc = 1'b0;
    if (st && model_busy == 0) begin
      exp_q.push_back('{xv, cyc});
      model_busy = FL;
      last_acc = 1'b1;
    end else if (model_busy > 0) begin
      model_busy--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame();
    exp_t e;
    int   bad;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_frame: got frame of %0d cycles expected none", cap.size());
    end else begin
      e = exp_q.pop_front();
      check("frame_len", cap.size(), FL);
      check("frame_start", first_cyc, e.acc + 1);
      bad = -1;
      for (int k = 0; k < cap.size(); k++) begin
        if (bad < 0 && cap[k] != exp_bit(e.w, k / D)) bad = k;
      end
      vectors++;
      if (bad >= 0) begin
        miscompares++;
        $display("FAIL frame_bits: word %h sample %0d got %b expected %b",
                 e.w, bad, cap[bad], exp_bit(e.w, bad / D));
      end
    end
    cap.delete();
  endtask

  always @(negedge clk) begin
    if (!clear) begin
      cap.delete();
      prev_busy = 1'b0;
    end else begin
      check("done", done, int'(prev_busy && !busy));
      if (busy) begin
        if (!prev_busy) first_cyc = cyc;
        cap.push_back(sdata);
      end else begin
        check("idle_sdata", sdata, 1);
        if (prev_busy) check_frame();
      end
      prev_busy = busy;
    end
  end

  task automatic drain();
    repeat (FL + 4) cycle(1'b0, rnd());
  endtask

  initial begin
    bit seq[$];
    bit got;
    clear = 1'b0; start = 1'b0; x = '0; start1 = 1'b0; x1 = 1'b0;
    #2;
    check("reset_sdata", sdata, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sdata1", sdata1, 1);
    @(posedge clk); @(posedge clk); #1;
    clear = 1'b1;

    cycle(1'b1, 8'hA5);
    drain();
    cycle(1'b1, 8'h07);
    drain();
    cycle(1'b1, 8'h03);
    drain();

    // Start with a different word mid-DATA must be ignored.
    cycle(1'b1, 8'h00);
    repeat (D * 3) cycle(1'b0, rnd());
    cycle(1'b1, 8'hFF);
    drain();

    // Asynchronous abort mid-DATA.
    cycle(1'b1, rnd());
    repeat (D * 4) cycle(1'b0, rnd());
    check("pre_abort_busy", busy, 1);
    clear = 1'b0;
    #1;
    check("abort_sdata", sdata, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_q.delete();
    model_busy = 0;
    @(posedge clk); @(posedge clk); #1;
    clear = 1'b1;
    cycle(1'b1, 8'h3C);
    drain();

    // Start held high: the second frame must follow the done cycle directly.
    cycle(1'b1, 8'h55);
    got = 1'b0;
    for (int i = 0; i < FL + 5 && !got; i++) begin
      cycle(1'b1, 8'hAA);
      got = last_acc;
    end
    check("held_start_second_accept", int'(got), 1);
    drain();

    repeat (3000) cycle($urandom_range(0, 7) == 0, rnd());
    drain();
    check("frames_pending", exp_q.size(), 0);

    // n=1, DIV=1 instance.
    seq.push_back(1'b0);
    seq.push_back(1'b1);
`ifdef SERIALIZADOR_PARITY_EN
    seq.push_back(1'b1);
`endif
    seq.push_back(1'b1);
    start1 = 1'b1; x1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; x1 = 1'b0;
    for (int k = 0; k < seq.size(); k++) begin
      check("d1_sdata", sdata1, int'(seq[k]));
      check("d1_busy", busy1, 1);
      check("d1_done_low", done1, 0);
      @(posedge clk); #1;
    end
    check("d1_done", done1, 1);
    check("d1_idle_busy", busy1, 0);
    check("d1_idle_sdata", sdata1, 1);
    @(posedge clk); #1;
    check("d1_done_pulse", done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
